arr_unit_sched: RTL
===================

Name: arr_unit_sched

Overview:
- Round-robin scheduler that shares one 4-bit arr→out transform unit among NREQ requesters.
- Each requester presents an operand under a req/ack handshake. The scheduler grants one requester at a time and drives the operand onto the shared unit's arr input.
- After the unit's fixed latency it captures the unit's out value and returns it to the granted requester with a one-cycle ack.
- Sits between client logic and the transform datapath; the unit itself is external.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 4, operand/result width; matches the unit's arr/out width.
- LAT, 1, unit latency in cycles from arr change to valid out (0..7; 0 = combinational unit).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  NREQ  request per requester; held high until the matching ack.
- req_data  input  NREQ*DW  packed operands; requester i occupies bits [i*DW +: DW]; held stable while req[i] is high.
- ack  output  NREQ  one-hot, one-cycle completion pulse.
- rsp_data  output  DW  result; valid only in the cycle ack is nonzero.
- grant_id  output  $clog2(NREQ)  index of the current or last granted requester.
- busy  output  1  high in every state except IDLE.
- unit_arr  output  DW  registered drive to the shared unit's arr input.
- unit_out  input  DW  shared unit's out.

Behaviour:
- Reset (rst=1 at a clk edge), all registers:
  - state=IDLE; ack=0; rsp_data=0; unit_arr=0; grant_id=0; busy=0.
  - rr pointer=0; latency counter=0.
- States: IDLE → ISSUE → WAIT → DONE → IDLE.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from the rr pointer, wrapping modulo NREQ.
  - Register grant_id=g and unit_arr=req_data[g]; go to ISSUE. Otherwise stay in IDLE.
- ISSUE: unit_arr is stable. Load the counter with LAT. If LAT=0, capture unit_out into the result register and go to DONE; else go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture unit_out and go to DONE.
  - unit_arr is held constant throughout.
- DONE:
  - ack[g]=1 and rsp_data=captured result, for exactly one cycle.
  - rr pointer=(g+1) mod NREQ; go to IDLE.
- Latency: request sampled in IDLE at cycle N → ack at cycle N+2+LAT. Back-to-back throughput is one result per LAT+3 cycles.
- The grant is fixed from IDLE until DONE. Requests arriving meanwhile wait.
- Simultaneous requests: served in rr order. With the pointer at 0 and all requesting, the order is 0,1,2,3,0,…
- Wrap-around: pointer NREQ-1 + grant → pointer 0. The search wraps past the top index.
- req[g] dropped mid-operation: the operation completes and ack[g] still pulses; the requester ignores it. req_data[g] is not re-sampled after IDLE.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. No ack is issued for the aborted operation.
- The ack bit of a requester is never asserted without a prior grant to it.
- Outputs are registered; no combinational path from req to ack.

Optional Feature:
- Macro ARR_SCHED_GRANT_CNT_EN.
- When defined:
  - Adds output grant_cnt, NREQ*8 bits, packed per requester.
  - Each 8-bit counter increments in the cycle its ack pulses and saturates at 255.
  - All counters clear on rst.
- When undefined: port and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst 2 cycles with req=4'b1111 → ack=0, busy=0, unit_arr=0, grant_id=0. First grant follows rst deassert.
- Single request (LAT=1): req=4'b0100 with req_data[2]=4'b0111 at cycle N → unit_arr=4'b0111 from N+1; ack=4'b0100 at N+3; rsp_data = unit value for 4'b0111 (identity stub: 4'b0111).
- Fairness: req=4'b1111 held, re-asserted after each ack → ack sequence 0001,0010,0100,1000,0001, spaced 4 cycles apart.
- Wrap/skip: pointer at 3, req=4'b0011 → grant 0 then 1. Then req=4'b1000 only → grant 3.
- Abort: assert rst during WAIT for requester 1 → no ack[1]; busy=0 next cycle; a re-request completes normally.
- LAT=0 build, req=4'b0001 → ack at N+2. With ARR_SCHED_GRANT_CNT_EN and 300 grants to requester 0 → grant_cnt[7:0]=255.

Source files
------------

// File: rtl/arr_unit_sched.sv
// Round-robin scheduler sharing one DW-bit arr->out transform unit among NREQ requesters.
// Optional per-requester grant counters: define ARR_SCHED_GRANT_CNT_EN.
module arr_unit_sched #(
    parameter int NREQ = 4,
    parameter int DW   = 4,
    parameter int LAT  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DW-1:0]       req_data,
    output logic [NREQ-1:0]          ack,
    output logic [DW-1:0]            rsp_data,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy,
    output logic [DW-1:0]            unit_arr,
`ifdef ARR_SCHED_GRANT_CNT_EN
    output logic [NREQ*8-1:0]        grant_cnt,
`endif
    input  logic [DW-1:0]            unit_out
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [DW-1:0]   arr_q, arr_d;
    logic [DW-1:0]   res_q, res_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            busy_q, busy_d;

    logic [2*NREQ-1:0] rot2_s;
    logic [NREQ-1:0]   rot_s;
    logic [IW:0]       sum_s;
    logic [IW-1:0]     pick_s;
    logic              found_s;
    logic [DW-1:0]     sel_data_s;
    logic [NREQ-1:0]   grant_oh_s;

    // Rotate requests so bit 0 is the rr pointer; the lowest set bit wins.
    always_comb begin
        rot2_s  = {req, req} >> rr_q;
        rot_s   = rot2_s[NREQ-1:0];
        found_s = 1'b0;
        sum_s   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            found_s = found_s | rot_s[k];
            sum_s   = rot_s[k] ? ({1'b0, rr_q} + (IW+1)'(k)) : sum_s;
        end
        if (sum_s >= (IW+1)'(NREQ)) begin
            pick_s = IW'(sum_s - (IW+1)'(NREQ));
        end else begin
            pick_s = sum_s[IW-1:0];
        end
        sel_data_s = '0;
        for (int k = 0; k < NREQ; k++) begin
            sel_data_s = (pick_s == IW'(k)) ? req_data[k*DW +: DW] : sel_data_s;
        end
        grant_oh_s = {{(NREQ-1){1'b0}}, 1'b1} << grant_q;
    end

    // Next-state and datapath decode for the IDLE/ISSUE/WAIT/DONE sequence.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        arr_d   = arr_q;
        res_d   = res_q;
        ack_d   = '0;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    grant_d = pick_s;
                    arr_d   = sel_data_s;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                cnt_d = 3'(LAT);
                if (LAT == 0) begin
                    res_d   = unit_out;
                    ack_d   = grant_oh_s;
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    res_d   = unit_out;
                    ack_d   = grant_oh_s;
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                if (grant_q == IW'(NREQ - 1)) begin
                    rr_d = '0;
                end else begin
                    rr_d = grant_q + IW'(1);
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            cnt_q   <= 3'd0;
            arr_q   <= '0;
            res_q   <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            arr_q   <= arr_d;
            res_q   <= res_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign ack      = ack_q;
    assign rsp_data = res_q;
    assign grant_id = grant_q;
    assign busy     = busy_q;
    assign unit_arr = arr_q;

`ifdef ARR_SCHED_GRANT_CNT_EN
    logic [NREQ*8-1:0] gcnt_q;

    // Saturating per-requester completion counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            gcnt_q <= '0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (ack_q[k] && (gcnt_q[k*8 +: 8] != 8'hFF)) begin
                    gcnt_q[k*8 +: 8] <= gcnt_q[k*8 +: 8] + 8'd1;
                end else begin
                    gcnt_q[k*8 +: 8] <= gcnt_q[k*8 +: 8];
                end
            end
        end
    end

    assign grant_cnt = gcnt_q;
`endif

endmodule
